// File: rtl/bounce_renderer_if.sv
// Video-timer-to-renderer bundle: timer-side sync/visible/coordinate inputs and
// the delayed syncs, RGB and bounce status produced by the renderer.
interface bounce_renderer_if #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned V_VISIBLE = 480
);
   localparam int unsigned XW = $clog2(H_VISIBLE);
   localparam int unsigned YW = $clog2(V_VISIBLE);

   logic          hsync_i;
   logic          vsync_i;
   logic          visible_i;
   logic [XW-1:0] pos_x_i;
   logic [YW-1:0] pos_y_i;
   logic          hsync_o;
   logic          vsync_o;
   logic [3:0]    red_o;
   logic [3:0]    green_o;
   logic [3:0]    blue_o;
   logic [15:0]   bounce_count_o;
   logic          corner_o;

   modport master (
      output hsync_i, vsync_i, visible_i, pos_x_i, pos_y_i,
      input  hsync_o, vsync_o, red_o, green_o, blue_o, bounce_count_o, corner_o
   );

   modport slave (
      input  hsync_i, vsync_i, visible_i, pos_x_i, pos_y_i,
      output hsync_o, vsync_o, red_o, green_o, blue_o, bounce_count_o, corner_o
   );
endinterface

// File: rtl/bounce_renderer.sv
// Draws a bouncing, colour-cycling rectangle behind the VGA timer; 2-cycle pixel latency.
// Optional screen border enabled by defining BOUNCE_RENDERER_BORDER_EN.
module bounce_renderer #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned BOX_W     = 64,
   parameter int unsigned BOX_H     = 48,
   parameter int unsigned SPEED_X   = 2,
   parameter int unsigned SPEED_Y   = 1
) (
   input logic              clk,
   input logic              rst,
   bounce_renderer_if.slave vid
);
   localparam int unsigned XW    = $clog2(H_VISIBLE);
   localparam int unsigned YW    = $clog2(V_VISIBLE);
   localparam int unsigned X_LIM = H_VISIBLE - BOX_W;
   localparam int unsigned Y_LIM = V_VISIBLE - BOX_H;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STEP_X,
      S_STEP_Y,
      S_COMMIT
   } state_t;

   state_t        state_q, state_d;
   logic          vsync_prev_q, vsync_prev_d;
   logic [XW-1:0] box_x_q, box_x_d, nx_q, nx_d;
   logic [YW-1:0] box_y_q, box_y_d, ny_q, ny_d;
   logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic          hit_x_q, hit_x_d, hit_y_q, hit_y_d;
   logic [2:0]    cidx_q, cidx_d;
   logic [15:0]   bounce_count_q, bounce_count_d;
   logic          corner_q, corner_d;
   logic          hsync_s1_q, hsync_s2_q, vsync_s1_q, vsync_s2_q;
   logic          inside_q, inside_d;
   logic [11:0]   rgb_q, rgb_d;
`ifdef BOUNCE_RENDERER_BORDER_EN
   logic          border_q, border_d;
`endif

   // Sums one bit wider than the coordinates so edge tests never wrap.
   logic [XW:0] x_sum, x_end;
   logic [YW:0] y_sum, y_end;
   logic        vsync_fall;

   assign x_sum      = {1'b0, box_x_q} + (XW+1)'(SPEED_X);
   assign y_sum      = {1'b0, box_y_q} + (YW+1)'(SPEED_Y);
   assign x_end      = {1'b0, box_x_q} + (XW+1)'(BOX_W);
   assign y_end      = {1'b0, box_y_q} + (YW+1)'(BOX_H);
   assign vsync_fall = vsync_prev_q & ~vid.vsync_i;

   function automatic logic [11:0] palette(input logic [2:0] idx);
      case (idx)
         3'd0:    palette = 12'hF00;
         3'd1:    palette = 12'h0F0;
         3'd2:    palette = 12'h00F;
         3'd3:    palette = 12'hFF0;
         3'd4:    palette = 12'h0FF;
         3'd5:    palette = 12'hF0F;
         3'd6:    palette = 12'hFFF;
         default: palette = 12'hF80;
      endcase
   endfunction

   // Frame-update FSM; box registers only change in COMMIT.
   always_comb begin
      state_d        = state_q;
      vsync_prev_d   = vid.vsync_i;
      box_x_d        = box_x_q;
      box_y_d        = box_y_q;
      nx_d           = nx_q;
      ny_d           = ny_q;
      dir_x_d        = dir_x_q;
      dir_y_d        = dir_y_q;
      hit_x_d        = hit_x_q;
      hit_y_d        = hit_y_q;
      cidx_d         = cidx_q;
      bounce_count_d = bounce_count_q;
      corner_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (vsync_fall) state_d = S_STEP_X;
         end
         S_STEP_X: begin
            if (!dir_x_q) begin
               if (x_sum >= (XW+1)'(X_LIM)) begin
                  nx_d    = XW'(X_LIM);
                  dir_x_d = 1'b1;
                  hit_x_d = 1'b1;
               end else begin
                  nx_d = x_sum[XW-1:0];
               end
            end else begin
               if ({1'b0, box_x_q} <= (XW+1)'(SPEED_X)) begin
                  nx_d    = '0;
                  dir_x_d = 1'b0;
                  hit_x_d = 1'b1;
               end else begin
                  nx_d = box_x_q - XW'(SPEED_X);
               end
            end
            state_d = S_STEP_Y;
         end
         S_STEP_Y: begin
            if (!dir_y_q) begin
               if (y_sum >= (YW+1)'(Y_LIM)) begin
                  ny_d    = YW'(Y_LIM);
                  dir_y_d = 1'b1;
                  hit_y_d = 1'b1;
               end else begin
                  ny_d = y_sum[YW-1:0];
               end
            end else begin
               if ({1'b0, box_y_q} <= (YW+1)'(SPEED_Y)) begin
                  ny_d    = '0;
                  dir_y_d = 1'b0;
                  hit_y_d = 1'b1;
               end else begin
                  ny_d = box_y_q - YW'(SPEED_Y);
               end
            end
            state_d = S_COMMIT;
         end
         S_COMMIT: begin
            box_x_d = nx_q;
            box_y_d = ny_q;
            if (hit_x_q | hit_y_q) begin
               cidx_d         = cidx_q + 3'd1;
               bounce_count_d = bounce_count_q + 16'd1;
            end
            corner_d = hit_x_q & hit_y_q;
            hit_x_d  = 1'b0;
            hit_y_d  = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pixel stage 1: box hit test (and border test when enabled).
   always_comb begin
      inside_d = vid.visible_i
               & (vid.pos_x_i >= box_x_q) & ({1'b0, vid.pos_x_i} < x_end)
               & (vid.pos_y_i >= box_y_q) & ({1'b0, vid.pos_y_i} < y_end);
`ifdef BOUNCE_RENDERER_BORDER_EN
      border_d = vid.visible_i
               & ((vid.pos_x_i == '0) | (vid.pos_x_i == XW'(H_VISIBLE - 1))
                | (vid.pos_y_i == '0) | (vid.pos_y_i == YW'(V_VISIBLE - 1)));
`endif
   end

   // Pixel stage 2: colour select; box wins over border.
   always_comb begin
      rgb_d = 12'h000;
      if (inside_q) begin
         rgb_d = palette(cidx_q);
      end
`ifdef BOUNCE_RENDERER_BORDER_EN
      else if (border_q) begin
         rgb_d = 12'hFFF;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         vsync_prev_q   <= 1'b1;
         box_x_q        <= '0;
         box_y_q        <= '0;
         nx_q           <= '0;
         ny_q           <= '0;
         dir_x_q        <= 1'b0;
         dir_y_q        <= 1'b0;
         hit_x_q        <= 1'b0;
         hit_y_q        <= 1'b0;
         cidx_q         <= 3'd0;
         bounce_count_q <= 16'd0;
         corner_q       <= 1'b0;
         hsync_s1_q     <= 1'b1;
         hsync_s2_q     <= 1'b1;
         vsync_s1_q     <= 1'b1;
         vsync_s2_q     <= 1'b1;
         inside_q       <= 1'b0;
         rgb_q          <= 12'h000;
`ifdef BOUNCE_RENDERER_BORDER_EN
         border_q       <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         vsync_prev_q   <= vsync_prev_d;
         box_x_q        <= box_x_d;
         box_y_q        <= box_y_d;
         nx_q           <= nx_d;
         ny_q           <= ny_d;
         dir_x_q        <= dir_x_d;
         dir_y_q        <= dir_y_d;
         hit_x_q        <= hit_x_d;
         hit_y_q        <= hit_y_d;
         cidx_q         <= cidx_d;
         bounce_count_q <= bounce_count_d;
         corner_q       <= corner_d;
         hsync_s1_q     <= vid.hsync_i;
         hsync_s2_q     <= hsync_s1_q;
         vsync_s1_q     <= vid.vsync_i;
         vsync_s2_q     <= vsync_s1_q;
         inside_q       <= inside_d;
         rgb_q          <= rgb_d;
`ifdef BOUNCE_RENDERER_BORDER_EN
         border_q       <= border_d;
`endif
      end
   end

   assign vid.hsync_o        = hsync_s2_q;
   assign vid.vsync_o        = vsync_s2_q;
   assign vid.red_o          = rgb_q[11:8];
   assign vid.green_o        = rgb_q[7:4];
   assign vid.blue_o         = rgb_q[3:0];
   assign vid.bounce_count_o = bounce_count_q;
   assign vid.corner_o       = corner_q;
endmodule

// File: tb/tb_bounce_renderer.sv
// Randomized pixel probes and frame updates on two renderer configurations,
// checked against a per-frame arithmetic model of the bouncing box.
module tb_bounce_renderer;
   localparam int unsigned HV = 640;
   localparam int unsigned VV = 480;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hs  = 1'b1;
   logic       vs  = 1'b1;
   logic       vis = 1'b0;
   logic [9:0] px  = '0;
   logic [8:0] py  = '0;

   always #5 clk = ~clk;

   bounce_renderer_if #(.H_VISIBLE(HV), .V_VISIBLE(VV)) vif_a ();
   bounce_renderer_if #(.H_VISIBLE(HV), .V_VISIBLE(VV)) vif_b ();

   assign vif_a.hsync_i   = hs;
   assign vif_a.vsync_i   = vs;
   assign vif_a.visible_i = vis;
   assign vif_a.pos_x_i   = px;
   assign vif_a.pos_y_i   = py;
   assign vif_b.hsync_i   = hs;
   assign vif_b.vsync_i   = vs;
   assign vif_b.visible_i = vis;
   assign vif_b.pos_x_i   = px;
   assign vif_b.pos_y_i   = py;

   bounce_renderer #(.H_VISIBLE(HV), .V_VISIBLE(VV)) dut_a (
      .clk(clk), .rst(rst), .vid(vif_a)
   );
   bounce_renderer #(.H_VISIBLE(HV), .V_VISIBLE(VV), .BOX_W(208), .BOX_H(48),
                     .SPEED_X(1), .SPEED_Y(1)) dut_b (
      .clk(clk), .rst(rst), .vid(vif_b)
   );

   // Reference model: one entry per DUT configuration.
   int bw [2] = '{64, 208};
   int bh [2] = '{48, 48};
   int sx [2] = '{2, 1};
   int sy [2] = '{1, 1};
   int mx [2], my [2], mdx [2], mdy [2], mc [2], mcnt [2], mcorner [2];
   logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                            12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};

   int n_checks = 0;
   int n_pass   = 0;
   int corner_seen [2] = '{0, 0};

   always @(posedge clk) begin
      if (vif_a.corner_o) corner_seen[0]++;
      if (vif_b.corner_o) corner_seen[1]++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         mx[k] = 0; my[k] = 0; mdx[k] = 0; mdy[k] = 0;
         mc[k] = 0; mcnt[k] = 0;
      end
   endfunction

   // Move one axis by one frame; returns 1 when it bounced.
   function automatic bit move_axis(inout int p, inout int dir, input int sp, input int lim);
      if (dir == 0) begin
         if (p + sp >= lim) begin p = lim; dir = 1; return 1'b1; end
         p = p + sp;
      end else begin
         if (p - sp <= 0) begin p = 0; dir = 0; return 1'b1; end
         p = p - sp;
      end
      return 1'b0;
   endfunction

   function automatic void model_frame();
      bit hx, hy;
      for (int k = 0; k < 2; k++) begin
         hx = move_axis(mx[k], mdx[k], sx[k], int'(HV) - bw[k]);
         hy = move_axis(my[k], mdy[k], sy[k], int'(VV) - bh[k]);
         if (hx || hy) begin
            mc[k]   = (mc[k] + 1) % 8;
            mcnt[k] = (mcnt[k] + 1) % 65536;
         end
         if (hx && hy) mcorner[k]++;
      end
   endfunction

   function automatic int exp_rgb(input int k, input bit v, input int x, input int y);
      if (v && x >= mx[k] && x < mx[k] + bw[k] && y >= my[k] && y < my[k] + bh[k])
         return int'(pal[mc[k]]);
`ifdef BOUNCE_RENDERER_BORDER_EN
      if (v && (x == 0 || x == int'(HV) - 1 || y == 0 || y == int'(VV) - 1))
         return 'hFFF;
`endif
      return 0;
   endfunction

   function automatic logic [11:0] rgb_of(input int k);
      if (k == 0) return {vif_a.red_o, vif_a.green_o, vif_a.blue_o};
      return {vif_b.red_o, vif_b.green_o, vif_b.blue_o};
   endfunction

   task automatic probe(input bit v, input int x, input int y, input bit h);
      @(negedge clk);
      vis = v; px = 10'(x); py = 9'(y); hs = h;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rgb_a", 32'(rgb_of(0)), 32'(exp_rgb(0, v, x, y)));
      check("rgb_b", 32'(rgb_of(1)), 32'(exp_rgb(1, v, x, y)));
      check("hsync_dly", 32'(vif_a.hsync_o), 32'(h));
      check("vsync_idle", 32'(vif_b.vsync_o), 32'd1);
   endtask

   // One vsync low pulse, wait for the update to land, then advance the model.
   task automatic frame_edge();
      @(negedge clk);
      vs = 1'b0;
      @(posedge clk); #1;
      check("vsync_d1", 32'(vif_a.vsync_o), 32'd1);
      @(negedge clk);
      vs = 1'b1;
      @(posedge clk); #1;
      check("vsync_d2", 32'(vif_b.vsync_o), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      model_frame();
      check("count_a", 32'(vif_a.bounce_count_o), 32'(mcnt[0]));
      check("count_b", 32'(vif_b.bounce_count_o), 32'(mcnt[1]));
   endtask

   task automatic random_probe();
      int k, x, y;
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
         x = int'($urandom_range(0, HV - 1));
         y = int'($urandom_range(0, VV - 1));
      end else begin
         x = mx[k] + int'($urandom_range(0, 4)) - 2;
         if ($urandom_range(0, 1) == 1) x = x + bw[k];
         y = my[k] + int'($urandom_range(0, bh[k] + 3)) - 2;
         if (x < 0) x = 0;
         if (x > int'(HV) - 1) x = int'(HV) - 1;
         if (y < 0) y = 0;
         if (y > int'(VV) - 1) y = int'(VV) - 1;
      end
      probe($urandom_range(0, 7) != 0, x, y, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      mcorner[0] = 0;
      mcorner[1] = 0;
      model_reset();

      // Outputs hold reset values even with live, contrary inputs.
      hs = 1'b0; vis = 1'b1; px = 10'd10; py = 9'd10;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hsync", 32'(vif_a.hsync_o), 32'd1);
      check("rst_vsync", 32'(vif_a.vsync_o), 32'd1);
      check("rst_rgb", 32'(rgb_of(0)), 32'd0);
      check("rst_count", 32'(vif_a.bounce_count_o), 32'd0);
      check("rst_corner", 32'(vif_a.corner_o), 32'd0);
      @(negedge clk);
      rst = 1'b0; hs = 1'b1;

      probe(1'b1, 10, 10, 1'b1);
      check("first_px_red", 32'(rgb_of(0)), 32'h F00);
      probe(1'b1, 64, 10, 1'b0);
      probe(1'b0, 10, 10, 1'b1);

      // Reset during STEP_Y discards the in-flight update.
      @(negedge clk);
      vs = 1'b0;
      @(posedge clk);
      @(negedge clk);
      vs = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (6) @(posedge clk);
      #1;
      check("abort_count", 32'(vif_a.bounce_count_o), 32'd0);
      probe(1'b1, 0, 0, 1'b1);
      check("abort_box_origin", 32'(rgb_of(0)), 32'hF00);

      frame_edge();
      probe(1'b1, 1, 0, 1'b1);
      probe(1'b1, 2, 1, 1'b1);
      check("edge1_box", 32'(rgb_of(0)), 32'hF00);
      probe(1'b1, 639, 200, 1'b1);

      for (int f = 2; f <= 432; f++) begin
         frame_edge();
         random_probe();
         random_probe();
         if (f == 288) begin
            check("a_cnt288", 32'(vif_a.bounce_count_o), 32'd1);
            probe(1'b1, 576, my[0], 1'b1);
            check("a_col288", 32'(rgb_of(0)), 32'h0F0);
         end
         if (f == 289) begin
            probe(1'b1, 574, my[0], 1'b1);
            probe(1'b1, 573, my[0], 1'b1);
         end
      end

      probe(1'b1, 432, 432, 1'b1);
      check("b_corner_col", 32'(rgb_of(1)), 32'h0F0);
      check("b_cnt432", 32'(vif_b.bounce_count_o), 32'd1);
      check("b_corner_once", 32'(corner_seen[1]), 32'd1);
      check("corner_b_model", 32'(corner_seen[1]), 32'(mcorner[1]));
      check("corner_a_model", 32'(corner_seen[0]), 32'(mcorner[0]));
      probe(1'b1, 0, 0, 1'b1);
      probe(1'b1, 639, 479, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/bounce_renderer.md
# bounce_renderer

Pixel-generation stage directly downstream of the VGA video timer. Consumes the timer's sync, visible and pixel-coordinate outputs and draws a solid rectangle on a black background. The rectangle moves once per frame and bounces off the screen edges, changing colour on each bounce. Emits 4:4:4 RGB plus syncs delayed to match, ready for the DAC/pin registers.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line (must match timer)
- V_VISIBLE, 480, visible lines per frame (must match timer)
- BOX_W, 64, rectangle width in pixels; 0 < BOX_W < H_VISIBLE
- BOX_H, 48, rectangle height in lines; 0 < BOX_H < V_VISIBLE
- SPEED_X, 2, horizontal step per frame; 0 < SPEED_X ≤ H_VISIBLE-BOX_W
- SPEED_Y, 1, vertical step per frame; 0 < SPEED_Y ≤ V_VISIBLE-BOX_H

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset: synchronous, active-high
- hsync_i  in  1  active-low hsync from timer
- vsync_i  in  1  active-low vsync from timer
- visible_i  in  1  high in active area
- pos_x_i  in  $clog2(H_VISIBLE)  current pixel column
- pos_y_i  in  $clog2(V_VISIBLE)  current pixel line
- hsync_o  out  1  hsync_i delayed 2 cycles
- vsync_o  out  1  vsync_i delayed 2 cycles
- red_o, green_o, blue_o  out  4 each  pixel colour
- bounce_count_o  out  16  frames in which at least one bounce occurred
- corner_o  out  1  one-cycle pulse when both axes bounce in the same frame

## Operation
- Box state: box_x, box_y (top-left, same widths as pos_*), dir_x, dir_y (0 = +, 1 = −), colour index cidx[2:0].
- Palette, cidx 0..7: F00, 0F0, 00F, FF0, 0FF, F0F, FFF, F80 (RGB hex nibbles).
- Update trigger: falling edge of vsync_i (registered previous value 1, current 0), i.e. during vertical blanking.
- FSM: IDLE → STEP_X → STEP_Y → COMMIT → IDLE. Edges seen outside IDLE are ignored.
- STEP_X, + direction: if box_x + SPEED_X ≥ H_VISIBLE−BOX_W, then nx = H_VISIBLE−BOX_W, flip dir_x, set hit_x; else nx = box_x + SPEED_X.
- STEP_X, − direction: if box_x ≤ SPEED_X, then nx = 0, flip dir_x, set hit_x; else nx = box_x − SPEED_X.
- STEP_Y: same rules with the Y parameters, producing ny and hit_y.
- All sums are computed one bit wider than the operands, so no wrap occurs.
- COMMIT: box_x ← nx and box_y ← ny.
  - If hit_x | hit_y: cidx += 1 (wraps 7 → 0) and bounce_count_o += 1 (wraps FFFF → 0).
  - If hit_x & hit_y: corner_o = 1 for this cycle only.
  - hit flags clear.
- Box registers used by the pixel path change only at COMMIT, so no tearing within a frame.
- Pixel stage 1 registers inside = visible_i & box_x ≤ pos_x_i < box_x+BOX_W & box_y ≤ pos_y_i < box_y+BOX_H.
- Pixel stage 2 registers RGB: palette[cidx] if inside, else 000.

## Timing
- Reset values:
  - hsync_o = vsync_o = 1; RGB = 0; bounce_count_o = 0; corner_o = 0.
  - box_x = box_y = 0; dir_x = dir_y = +; cidx = 0; FSM = IDLE; sync/visible pipelines cleared to 1/1/0.
  - The vsync edge detector's previous value resets to 1.
- Pixel latency is 2 cycles from inputs to RGB, with syncs delayed identically.
- Box update completes 4 cycles after the vsync falling edge is sampled: edge → STEP_X → STEP_Y → COMMIT. New position is visible from the next active line.
- rst asserted mid-FSM aborts the update with no partial commit; all state returns to reset values on the next edge.
- RGB is 0 whenever visible is low (blanking), independent of box position.

## Configuration
- BOUNCE_RENDERER_BORDER_EN defined: visible pixels with pos_x_i ∈ {0, H_VISIBLE−1} or pos_y_i ∈ {0, V_VISIBLE−1} output FFF. The box has priority over the border. Latency is unchanged.
- Undefined: no border logic; background is 000 everywhere outside the box.

## Test plan
- Reset, then drive visible_i=1 at pos (10,10) → two cycles later RGB = F00. At pos (64,10) → RGB = 000; syncs are the inputs delayed 2 cycles.
- One vsync falling edge (defaults) → box (2,1) 4 cycles after the edge; pixel (1,0) now 000, pixel (2,1) F00.
- 288 vsync edges (defaults) → box_x = 576, dir_x = −, bounce_count_o = 1, colour 0F0. Edge 289 → box_x = 574.
- SPEED_X=1, BOX_W=208, 432 edges → box at (432,432), corner_o pulses once, bounce_count_o = 1, colour 0F0.
- rst asserted in STEP_Y of the first update → box stays (0,0), count 0, FSM IDLE. The next edge moves the box to (2,1).
- With BOUNCE_RENDERER_BORDER_EN: pixel (639,200) → FFF, pixel (0,0) → F00 (box wins); without the macro, pixel (639,200) → 000.
